// File: rtl/cache_fill_if.sv
// cache_fill_if
//   Groups the miss request, memory return and cache write signals of one
//   cache fill engine.
//
//   Handshake semantics, in one place:
//     miss_detected     : one-cycle request from the cache. The FSM only
//                         looks at it while idle. There is no ready; the
//                         cache holds its miss until fsm_busy rises.
//     mem_read          : one read request per cycle while high. Memory has
//                         no ready and accepts every request it sees.
//     memory_data_valid : one returned word per high cycle, in request order.
//                         There is no backpressure, so the FSM takes every
//                         valid beat during a fill.
//     write_data_array / write_tag_array : single-cycle write strobes to the
//                         cache arrays. They are qualified by nothing else.
//
//   Modports:
//     master : cache/memory side. It drives the miss and return signals.
//     slave  : the fill FSM.
interface cache_fill_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  miss_detected;
    logic [ADDR_WIDTH-1:0] miss_address;
    logic                  memory_data_valid;
    logic [DATA_WIDTH-1:0] memory_data;
    logic                  fsm_busy;
    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] memory_address;
    logic                  write_data_array;
    logic                  write_tag_array;
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic [DATA_WIDTH-1:0] cache_data;

    modport master (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, mem_read, memory_address, write_data_array,
               write_tag_array, cache_addr, cache_data
    );

    modport slave (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, mem_read, memory_address, write_data_array,
               write_tag_array, cache_addr, cache_data
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
//   Miss handler placed between a 2-way cache and a multi-cycle main memory.
//   On a miss it requests every word of the missing block, one request per
//   cycle. It writes each returned word into the cache data array. It writes
//   the tag/valid/LRU metadata together with the last word.
//
//   Ports:
//     clk         : rising-edge clock
//     rst_n       : asynchronous active-low reset
//     bus         : cache_fill_if.slave. It carries miss_detected/
//                   miss_address in, memory_data_valid/memory_data in,
//                   fsm_busy, mem_read, memory_address, write_data_array,
//                   write_tag_array, cache_addr and cache_data out.
//     o_dbg_state : current FSM state (0 = IDLE, 1 = WAIT)
//
// rca_16bit: plain ripple-carry adder (carry-in 0, carry-out not needed).
module rca_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum
);
    logic [15:0] w_carry;

    assign w_carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            assign o_sum[gi] = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
            if (gi < 15) begin : g_carry
                assign w_carry[gi+1] = (i_a[gi] & i_b[gi]) |
                                       (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
            end
        end
    endgenerate
endmodule

module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    cache_fill_if.slave      bus,
    output logic             o_dbg_state
);
    // The counters need one extra bit so that issue_cnt can hold the
    // saturated value WORDS_PER_BLOCK.
    localparam int                    CNT_W      = $clog2(WORDS_PER_BLOCK) + 1;
    localparam logic [CNT_W-1:0]      WPB        = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]      LAST       = CNT_W'(WORDS_PER_BLOCK - 1);
    // A block holds WORDS_PER_BLOCK 16-bit words, so its byte size is 2*WPB.
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ~ADDR_WIDTH'((2 * WORDS_PER_BLOCK) - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                r_state,     w_state_next;
    logic [ADDR_WIDTH-1:0] r_base,      w_base_next;
    logic [CNT_W-1:0]      r_issue_cnt, w_issue_next;
    logic [CNT_W-1:0]      r_recv_cnt,  w_recv_next;

    logic [ADDR_WIDTH-1:0] w_issue_off;
    logic [ADDR_WIDTH-1:0] w_recv_off;
    logic [ADDR_WIDTH-1:0] w_issue_addr;
    logic [ADDR_WIDTH-1:0] w_recv_addr;

    // Word index to byte offset.
    assign w_issue_off = ADDR_WIDTH'({r_issue_cnt, 1'b0});
    assign w_recv_off  = ADDR_WIDTH'({r_recv_cnt, 1'b0});

    rca_16bit u_issue_add (
        .i_a   (r_base),
        .i_b   (w_issue_off),
        .o_sum (w_issue_addr)
    );

    rca_16bit u_recv_add (
        .i_a   (r_base),
        .i_b   (w_recv_off),
        .o_sum (w_recv_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_base      <= w_base_next;
            r_issue_cnt <= w_issue_next;
            r_recv_cnt  <= w_recv_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_base_next          = r_base;
        w_issue_next         = r_issue_cnt;
        w_recv_next          = r_recv_cnt;
        bus.fsm_busy         = 1'b0;
        bus.mem_read         = 1'b0;
        bus.memory_address   = '0;
        bus.write_data_array = 1'b0;
        bus.write_tag_array  = 1'b0;
        bus.cache_addr       = '0;
        bus.cache_data       = '0;

        case (r_state)
            IDLE: begin
                w_issue_next = '0;
                w_recv_next  = '0;
                if (bus.miss_detected) begin
                    w_base_next  = bus.miss_address & BLOCK_MASK;
                    w_state_next = WAIT;
                end
            end

            WAIT: begin
                bus.fsm_busy   = 1'b1;
                bus.mem_read   = (r_issue_cnt < WPB);
                // Gated so that the saturated count (base + block size)
                // never appears on the bus, even for the top block.
                if (bus.mem_read) begin
                    bus.memory_address = w_issue_addr;
                    w_issue_next       = r_issue_cnt + CNT_W'(1);
                end

                bus.cache_addr = w_recv_addr;
                bus.cache_data = bus.memory_data;
                if (bus.memory_data_valid) begin
                    bus.write_data_array = 1'b1;
                    w_recv_next          = r_recv_cnt + CNT_W'(1);
                    if (r_recv_cnt == LAST) begin
                        bus.write_tag_array = 1'b1;
                        w_state_next        = IDLE;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign o_dbg_state = (r_state == WAIT);
endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;
  localparam int WPB = 8;

  logic clk;
  logic rst_n;
  logic dbg_state;

  cache_fill_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  cache_fill_fsm #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(WPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Memory model: due cycle and data for each request still outstanding.
  int          pend_due[$];
  logic [15:0] exp_q[$];
  int          mem_lat  = 4;
  int          max_gap  = 0;
  int          gap_left = 0;

  // Reference model of one fill: which block, how many words asked/received.
  bit          m_busy   = 0;
  logic [15:0] m_base   = 0;
  int          m_issued = 0;
  int          m_recv   = 0;

  // Per-fill observations of DUT outputs.
  int n_req, n_wr, n_tag, t_tag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick(input logic rstv, input logic miss, input logic [15:0] maddr, input logic spur);
    logic        v;
    logic [15:0] d;
    logic        exp_busy, exp_rd, exp_wr;
    @(posedge clk);
    #1;
    rst_n = rstv;
    bus.miss_detected = miss;
    bus.miss_address  = maddr;
    v = 1'b0;
    d = 16'($urandom);
    if (!rstv) begin
      pend_due.delete();
      exp_q.delete();
      gap_left = 0;
    end
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      if (gap_left > 0) begin
        gap_left--;
      end else begin
        v = 1'b1;
        d = exp_q.pop_front();
        void'(pend_due.pop_front());
        gap_left = $urandom_range(0, max_gap);
      end
    end else if (spur && !m_busy) begin
      v = 1'b1;
    end
    bus.memory_data_valid = v;
    bus.memory_data       = d;

    @(negedge clk);
    exp_busy = rstv && m_busy;
    exp_rd   = exp_busy && (m_issued < WPB);
    exp_wr   = exp_busy && v;
    check("fsm_busy", bus.fsm_busy, exp_busy);
    if (exp_busy) begin
      check("mem_read", bus.mem_read, exp_rd);
      if (exp_rd) check("memory_address", bus.memory_address, 16'(m_base + 2 * m_issued));
      check("write_data_array", bus.write_data_array, exp_wr);
      check("write_tag_array", bus.write_tag_array, exp_wr && (m_recv == WPB - 1));
      if (exp_wr) begin
        check("cache_addr", bus.cache_addr, 16'(m_base + 2 * m_recv));
        check("cache_data", bus.cache_data, d);
      end
    end else begin
      check("idle_ctl", {bus.mem_read, bus.write_data_array, bus.write_tag_array}, 3'b000);
      check("idle_addr", {bus.memory_address, bus.cache_addr}, 32'h0);
      check("idle_data", bus.cache_data, 16'h0);
    end

    // Observed DUT activity feeds the memory model and the per-fill counts.
    if (bus.mem_read) begin
      pend_due.push_back(cyc + mem_lat);
      exp_q.push_back(16'($urandom));
      n_req++;
    end
    if (bus.write_data_array) n_wr++;
    if (bus.write_tag_array) begin
      n_tag++;
      t_tag = cyc;
    end

    // Advance the reference model.
    if (!rstv) begin
      m_busy = 0;
    end else if (m_busy) begin
      if (exp_rd) m_issued++;
      if (v) begin
        if (m_recv == WPB - 1) m_busy = 0;
        else m_recv++;
      end
    end else if (miss) begin
      m_busy   = 1;
      m_base   = maddr & 16'hFFF0;
      m_issued = 0;
      m_recv   = 0;
    end
    cyc++;
  endtask

  // One complete fill. rst_after >= 0 pulses reset once that many words
  // have been written.
  task automatic run_fill(input logic [15:0] addr, input bit mid_miss, input int rst_after);
    int c0;
    int budget;
    n_req = 0;
    n_wr  = 0;
    n_tag = 0;
    t_tag = -1;
    c0    = cyc;
    tick(1'b1, 1'b1, addr, 1'b0);
    budget = 0;
    while (m_busy && budget < 300) begin
      if (rst_after >= 0 && m_recv == rst_after) begin
        tick(1'b0, 1'($urandom), 16'($urandom), 1'b0);
        check("partial_writes", n_wr, rst_after);
        check("partial_no_tag", n_tag, 0);
        return;
      end
      tick(1'b1, mid_miss && (budget == 3), 16'h4000, 1'b0);
      budget++;
    end
    if (budget >= 300) check("fill_timeout", 1, 0);
    check("fill_requests", n_req, WPB);
    check("fill_writes", n_wr, WPB);
    check("fill_tags", n_tag, 1);
    if (max_gap == 0) check("busy_latency", t_tag + 1 - c0, 1 + (WPB - 1) + mem_lat + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = '0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = '0;

    // Reset with random inputs.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'($urandom), 16'($urandom), 1'($urandom));
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    check("state_idle_after_reset", dbg_state, 1'b0);

    // Basic fill, latency 4.
    mem_lat = 4;
    max_gap = 0;
    run_fill(16'h1236, 1'b0, -1);

    // Spurious valid while idle.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 16'h0, 1'b1);

    // Second miss mid-fill must not move the base.
    run_fill(16'h1236, 1'b1, -1);

    // Stalled returns.
    max_gap = 3;
    run_fill(16'h5678, 1'b0, -1);
    run_fill(16'h9ABC, 1'b1, -1);

    // Reset mid-fill, then restart.
    max_gap = 0;
    run_fill(16'h2222, 1'b0, 3);
    tick(1'b1, 1'b0, 16'h0, 1'b1);
    run_fill(16'h2222, 1'b0, -1);

    // Top-of-memory block, then back-to-back miss in the first idle cycle.
    run_fill(16'hFFFF, 1'b0, -1);
    run_fill(16'hABCD, 1'b0, -1);

    // Randomized fills.
    for (int i = 0; i < 8; i++) begin
      mem_lat = $urandom_range(1, 6);
      max_gap = $urandom_range(0, 3);
      run_fill(16'($urandom), 1'($urandom), -1);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick(1'b1, 1'b0, 16'h0, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
